// File: rtl/nand_page_xfer_pkg.sv
// Shared types for the NAND page transfer engine: FSM states, transfer direction
// and a small constant helper.
package nand_xfer_pkg;

   typedef enum logic [3:0] {
      IDLE,
      P_FETCH,
      P_LOAD,
      P_WLO,
      P_WHI,
      R_WAIT,
      R_RLO,
      R_RHI,
      DONE
   } xfer_state_e;

   typedef enum logic {
      XFER_PROG = 1'b0,
      XFER_READ = 1'b1
   } xfer_dir_e;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/nand_page_xfer_if.sv
// Signal bundle of the page transfer engine: sequencer handshake, page-buffer
// controller port and NAND pins. The engine side uses the master modport.
interface nand_page_xfer_if #(
   parameter int DataWidth = 16
) ();

   logic                 start;
   logic                 dir;
   logic                 busy;
   logic                 done;
   logic                 cntrl_sel;
   logic                 cntrl_re;
   logic                 cntrl_we;
   logic [DataWidth-1:0] cntrl_in;
   logic [DataWidth-1:0] cntrl_out;
   logic [DataWidth-1:0] io_out;
   logic                 io_oe;
   logic [DataWidth-1:0] io_in;
   logic                 we_n;
   logic                 re_n;
   logic                 rb_n;

   modport master (
      input  start, dir, cntrl_out, io_in, rb_n,
      output busy, done, cntrl_sel, cntrl_re, cntrl_we, cntrl_in,
             io_out, io_oe, we_n, re_n
   );

   modport slave (
      output start, dir, cntrl_out, io_in, rb_n,
      input  busy, done, cntrl_sel, cntrl_re, cntrl_we, cntrl_in,
             io_out, io_oe, we_n, re_n
   );

endinterface

// File: rtl/nand_page_xfer_strobe_timer.sv
// Load/count-down phase timer. Loading N-1 on phase entry makes exp_o rise on
// the N-th cycle of the phase.
module nand_strobe_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         exp_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 cnt_q <= '0;
      else if (load_i)         cnt_q <= load_val_i;
      else if (cnt_q != '0)    cnt_q <= cnt_q - W'(1);
   end

   assign exp_o = (cnt_q == '0);

endmodule

// File: rtl/nand_page_xfer.sv
// Page transfer engine between the page buffer controller port and the NAND pins.
// PROGRAM streams buffer words out with we_n strobes; READ strobes re_n and fills the buffer.
module nand_page_xfer
   import nand_xfer_pkg::*;
#(
   parameter int DataWidth = 16,
   parameter int PageWords = 2048,
   parameter int TWP       = 2,
   parameter int TWH       = 2,
   parameter int TRP       = 2,
   parameter int TREH      = 2
) (
   input logic               clk,
   input logic               rst,
   nand_page_xfer_if.master  bus
);

   localparam int CW = $clog2(PageWords + 1);
   localparam int TW = $clog2(max4(TWP, TWH, TRP, TREH) + 1);

   localparam logic [CW-1:0] LAST_CNT = CW'(PageWords);
   localparam logic [TW-1:0] TWP_L    = TW'(TWP - 1);
   localparam logic [TW-1:0] TWH_L    = TW'(TWH - 1);
   localparam logic [TW-1:0] TRP_L    = TW'(TRP - 1);
   localparam logic [TW-1:0] TREH_L   = TW'(TREH - 1);

   xfer_state_e          state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
   logic [DataWidth-1:0] io_out_q, rd_q;
   logic                 act_q, done_q, cre_q, cwe_q, ioe_q, we_n_q, re_n_q;
   logic                 tmr_load, tmr_exp;
   logic [TW-1:0]        tmr_val;

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               cnt_d   = '0;
               state_d = (xfer_dir_e'(bus.dir) == XFER_READ) ? R_WAIT : P_FETCH;
            end
         end
         P_FETCH: state_d = P_LOAD;
         P_LOAD:  state_d = P_WLO;
         P_WLO:   if (tmr_exp) state_d = P_WHI;
         P_WHI: begin
            if (tmr_exp) begin
               cnt_d   = cnt_inc;
               state_d = (cnt_inc == LAST_CNT) ? DONE : P_FETCH;
            end
         end
         // rb_n only gates the start of a read; it is not watched afterwards
         R_WAIT:  if (bus.rb_n) state_d = R_RLO;
         R_RLO:   if (tmr_exp) state_d = R_RHI;
         R_RHI: begin
            if (tmr_exp) begin
               cnt_d   = cnt_inc;
               state_d = (cnt_inc == LAST_CNT) ? DONE : R_RLO;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // One timer serves every strobe phase: reload on each state change.
   always_comb begin
      tmr_load = (state_d != state_q);
      tmr_val  = '0;
      unique case (state_d)
         P_WLO:   tmr_val = TWP_L;
         P_WHI:   tmr_val = TWH_L;
         R_RLO:   tmr_val = TRP_L;
         R_RHI:   tmr_val = TREH_L;
         default: tmr_val = '0;
      endcase
   end

   nand_strobe_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .exp_o      (tmr_exp)
   );

   // Pin outputs are registered from the next state so they line up with state_q glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         io_out_q <= '0;
         rd_q     <= '0;
         act_q    <= 1'b0;
         done_q   <= 1'b0;
         cre_q    <= 1'b0;
         cwe_q    <= 1'b0;
         ioe_q    <= 1'b0;
         we_n_q   <= 1'b1;
         re_n_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         act_q   <= (state_d != IDLE) && (state_d != DONE);
         done_q  <= (state_d == DONE);
         cre_q   <= (state_d == P_FETCH);
         cwe_q   <= (state_d == R_RHI) && (state_q != R_RHI);
         ioe_q   <= state_d inside {P_FETCH, P_LOAD, P_WLO, P_WHI};
         we_n_q  <= (state_d != P_WLO);
         re_n_q  <= (state_d != R_RLO);
         if (state_q == P_LOAD)            io_out_q <= bus.cntrl_out;
         if (state_q == R_RLO && tmr_exp)  rd_q     <= bus.io_in;
      end
   end

   assign bus.busy      = act_q;
   assign bus.cntrl_sel = act_q;
   assign bus.done      = done_q;
   assign bus.cntrl_re  = cre_q;
   assign bus.cntrl_we  = cwe_q;
   assign bus.cntrl_in  = rd_q;
   assign bus.io_out    = io_out_q;
   assign bus.io_oe     = ioe_q;
   assign bus.we_n      = we_n_q;
   assign bus.re_n      = re_n_q;

endmodule
